// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin owner of one shared register with hold limit and lock override
module shared_reg_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4,
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW = $clog2(MAX_HOLD + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [OW-1:0]         owner,
    output logic                  busy,
    output logic [WIDTH-1:0]      q,
    output logic [WIDTH-1:0]      q_not
);
    typedef enum logic {IDLE, OWN} state_t;
    state_t                  state_q, state_d;
    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic [OW-1:0]           owner_q, owner_d, last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0]        data_q, data_d;
    logic [NREQ-1:0][WIDTH-1:0] wd;
    logic [NREQ-1:0]         cand;
    logic [OW-1:0]           base, idx, win;
    logic                    found, keep;
    assign wd = wdata;
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        data_d  = data_q;
        base    = (state_q == IDLE) ? last_q : owner_q;
        cand    = (state_q == IDLE) ? req : req & ~gnt_q;
        found   = 1'b0;
        win     = '0;
        idx     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = OW'((int'(base) + i) % NREQ);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        cnt_inc = (cnt_q == CW'(MAX_HOLD)) ? cnt_q : cnt_q + 1'b1;
        keep    = req[owner_q] && (cnt_inc != CW'(MAX_HOLD) || lock[owner_q] || !found);
        if (state_q == OWN && req[owner_q])
            data_d = wd[owner_q];
        if (state_q == OWN && keep) begin
            cnt_d = cnt_inc;
        end else if (found) begin
            state_d    = OWN;
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            owner_d    = win;
            cnt_d      = '0;
            last_d     = win;
        end else if (state_q == OWN) begin
            state_d = IDLE;
            gnt_d   = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            last_q  <= OW'(NREQ - 1);
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end
    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = (state_q == OWN);
    assign q     = data_q;
    assign q_not = ~data_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed self-checking bench for shared_reg_arbiter
module tb_shared_reg_arbiter;
    logic        clk = 0;
    logic        reset;
    logic [3:0]  req, lock, gnt;
    logic [31:0] wdata;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q, q_not;
    int          n_tests = 0, n_fail = 0;

    shared_reg_arbiter #(.NREQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
        .gnt(gnt), .owner(owner), .busy(busy), .q(q), .q_not(q_not)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wd(input int k, input logic [7:0] v);
        wdata[k*8 +: 8] = v;
    endtask

    initial begin
        #1;
        reset = 1;
        req   = 4'($urandom);
        lock  = 4'($urandom);
        wdata = $urandom;
        tick();
        req = 4'($urandom);
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_q", 32'(q), 32'h00);
        check("rst_qnot", 32'(q_not), 32'hFF);

        reset = 0; lock = 0; req = 4'b0010; wdata = 0; set_wd(1, 8'hA5);
        tick();
        check("single_gnt", 32'(gnt), 32'b0010);
        check("single_owner", 32'(owner), 32'd1);
        check("single_q_early", 32'(q), 32'h00);
        tick();
        check("single_q", 32'(q), 32'hA5);
        check("single_qnot", 32'(q_not), 32'h5A);
        req = 0;
        tick();
        check("idle_gnt", 32'(gnt), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);

        reset = 1;
        tick();
        reset = 0; req = 4'b1111;
        for (int k = 0; k < 4; k++) set_wd(k, 8'h10 + 8'(k));
        tick();
        check("cont_first", 32'(gnt), 32'b0001);
        for (int o = 0; o < 4; o++) begin
            for (int w = 1; w <= 4; w++) begin
                tick();
                check($sformatf("cont_q_o%0d_w%0d", o, w), 32'(q), 32'h10 + o);
                check($sformatf("cont_busy_o%0d_w%0d", o, w), 32'(busy), 32'h1);
                check($sformatf("cont_gnt_o%0d_w%0d", o, w), 32'(gnt),
                      (w < 4) ? (32'h1 << o) : (32'h1 << ((o + 1) % 4)));
            end
        end

        req = 4'b0011; lock = 4'b0001; set_wd(0, 8'hC1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("lock_gnt_%0d", c), 32'(gnt), 32'b0001);
        end
        check("lock_q", 32'(q), 32'hC1);
        lock = 0;
        tick();
        check("unlock_gnt", 32'(gnt), 32'b0010);

        req = 4'b0100;
        tick();
        check("to2_gnt", 32'(gnt), 32'b0100);
        req = 4'b1101; set_wd(2, 8'h77);
        tick();
        check("own2_q", 32'(q), 32'h77);
        check("own2_gnt", 32'(gnt), 32'b0100);
        req = 4'b1001; set_wd(2, 8'h99); set_wd(3, 8'h33);
        tick();
        check("vol_gnt", 32'(gnt), 32'b1000);
        check("vol_nowrite", 32'(q), 32'h77);
        tick();
        check("own3_q", 32'(q), 32'h33);
        req = 4'b0001;
        tick();
        check("then0_gnt", 32'(gnt), 32'b0001);
        check("then0_q", 32'(q), 32'h33);

        req = 4'b0010; set_wd(1, 8'h3C);
        tick();
        check("pre_rst_gnt", 32'(gnt), 32'b0010);
        check("pre_rst_q", 32'(q), 32'h33);
        reset = 1;
        tick();
        check("mid_rst_q", 32'(q), 32'h00);
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        reset = 0; req = 4'b0011;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'b0001);
        check("post_rst_owner", 32'(owner), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
